wb_rr_interconnect: RTL and testbench

Parametrised N-master to 1-slave Wishbone interconnect that replaces the fixed two-cache I/D interconnect between the L1 caches and the shared memory port. It arbitrates N requesters with registered round-robin grants and holds each grant for one complete transfer. It forwards the granted master's bus to the slave and routes ACK/RTY back to that master only. A programmable watchdog terminates transfers the slave never answers.

---
 rtl/lc3b_types.sv | 19 +
 rtl/rr_pick.sv | 23 ++
 rtl/wb_rr_interconnect.sv | 126 ++++++++++++
 tb/tb_wb_rr_interconnect.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type and constant package.
// Holds the Wishbone widths and the interconnect FSM state type.
package lc3b_types;

  localparam int WB_DW   = 128;
  localparam int WB_AW   = 12;
  localparam int WB_SELW = WB_DW / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wb_ic_state_t;

  // The watchdog counter is at least one bit wide, even when the watchdog is disabled.
  function automatic int wdog_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// It scans last+1, last+2, ... modulo N and returns the first requester it finds.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          valid
);

  // The loop runs downwards, so the candidate nearest to last+1 is written last and wins.
  always_comb begin
    pick = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % N)]) pick = IW'((int'(last) + k) % N);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wb_rr_interconnect.sv
// N-master to 1-slave Wishbone interconnect with round-robin arbitration.
// Each grant is held for one complete transfer, and a watchdog ends transfers the slave never answers.
module wb_rr_interconnect
  import lc3b_types::*;
#(
  parameter int N       = 2,
  parameter int DW      = WB_DW,
  parameter int AW      = WB_AW,
  parameter int SELW    = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      m_cyc,
  input  logic [N-1:0]      m_stb,
  input  logic [N-1:0]      m_we,
  input  logic [N*SELW-1:0] m_sel,
  input  logic [N*AW-1:0]   m_adr,
  input  logic [N*DW-1:0]   m_datm,
  output logic [DW-1:0]     m_dats,
  output logic [N-1:0]      m_ack,
  output logic [N-1:0]      m_rty,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [SELW-1:0]   s_sel,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_datm,
  input  logic [DW-1:0]     s_dats,
  input  logic              s_ack,
  input  logic              s_rty,
  output logic              timeout_err
);

  localparam int IW  = $clog2(N);
  localparam int WDW = wdog_width(TIMEOUT);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT);
  localparam logic [IW-1:0]  LAST_RST = IW'(N - 1);

  wb_ic_state_t   state_q;
  logic [IW-1:0]  grant_q;
  logic [IW-1:0]  last_q;
  logic [WDW-1:0] wdog_q;

  logic [N-1:0]  req;
  logic [IW-1:0] pick;
  logic          pick_valid;
  logic          g_cyc;
  logic          g_stb;
  logic          active;
  logic          wd_fire;
  logic          release_c;

  assign req = m_cyc & m_stb;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign g_cyc  = m_cyc[grant_q];
  assign g_stb  = m_stb[grant_q];
  // When the granted master drops cyc, the transfer is aborted and nothing is forwarded in that cycle.
  assign active = (state_q == BUSY) && g_cyc;

  generate
    if (TIMEOUT != 0) begin : g_wd
      assign wd_fire = active && !s_ack && !s_rty && (wdog_q == WD_MAX);
    end else begin : g_nowd
      assign wd_fire = 1'b0;
    end
  endgenerate

  assign release_c = (state_q == BUSY) && (!g_cyc || s_ack || s_rty || wd_fire);

  assign s_cyc       = active && !wd_fire;
  assign s_stb       = active && g_stb && !wd_fire;
  assign s_we        = active && m_we[grant_q];
  assign s_sel       = active ? m_sel[int'(grant_q) * SELW +: SELW] : '0;
  assign s_adr       = active ? m_adr[int'(grant_q) * AW +: AW]     : '0;
  assign s_datm      = active ? m_datm[int'(grant_q) * DW +: DW]    : '0;
  assign m_dats      = s_dats;
  assign timeout_err = wd_fire;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_resp
      assign m_ack[gi] = active && (grant_q == IW'(gi)) && s_ack;
      assign m_rty[gi] = active && (grant_q == IW'(gi)) && (s_rty || wd_fire);
    end
  endgenerate

  // The watchdog counter saturates at TIMEOUT, so it cannot wrap while the slave stays silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      wdog_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick;
            wdog_q  <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (release_c) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end else if (wdog_q != WD_MAX) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Directed bench for wb_rr_interconnect with N=4 and TIMEOUT=4.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled on the falling edge.
module tb_wb_rr_interconnect;

  localparam int N       = 4;
  localparam int DW      = 128;
  localparam int AW      = 12;
  localparam int SELW    = 16;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      m_cyc;
  logic [N-1:0]      m_stb;
  logic [N-1:0]      m_we;
  logic [N*SELW-1:0] m_sel;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_datm;
  logic [DW-1:0]     m_dats;
  logic [N-1:0]      m_ack;
  logic [N-1:0]      m_rty;
  logic              s_cyc;
  logic              s_stb;
  logic              s_we;
  logic [SELW-1:0]   s_sel;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_datm;
  logic [DW-1:0]     s_dats;
  logic              s_ack;
  logic              s_rty;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] WDATA = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;

  wb_rr_interconnect #(
    .N       (N),
    .DW      (DW),
    .AW      (AW),
    .SELW    (SELW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_cyc       (m_cyc),
    .m_stb       (m_stb),
    .m_we        (m_we),
    .m_sel       (m_sel),
    .m_adr       (m_adr),
    .m_datm      (m_datm),
    .m_dats      (m_dats),
    .m_ack       (m_ack),
    .m_rty       (m_rty),
    .s_cyc       (s_cyc),
    .s_stb       (s_stb),
    .s_we        (s_we),
    .s_sel       (s_sel),
    .s_adr       (s_adr),
    .s_datm      (s_datm),
    .s_dats      (s_dats),
    .s_ack       (s_ack),
    .s_rty       (s_rty),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] adr_of(input int i);
    return AW'(12'h100 + 16 * i);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic on);
    m_cyc[i] = on;
    m_stb[i] = on;
  endtask

  task automatic clear_inputs();
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    s_ack = 1'b0;
    s_rty = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(2, 1'b1);
    next_cycle();
    s_dats = 128'h0F0F_1234_5678_9ABC_DEF0_1357_2468_ACE0;
    next_cycle();
    sample();
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got %b exp 0", s_cyc); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb got %b exp 0", s_stb); end
    checks++; if ({s_we, s_sel, s_adr, s_datm} !== '0) begin errors++; $display("FAIL reset_s_fields got we=%b sel=%h adr=%h exp 0", s_we, s_sel, s_adr); end
    checks++; if (m_ack !== 4'b0000) begin errors++; $display("FAIL reset_m_ack got %b exp 0000", m_ack); end
    checks++; if (m_rty !== 4'b0000) begin errors++; $display("FAIL reset_m_rty got %b exp 0000", m_rty); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
    checks++; if (m_dats !== 128'h0F0F_1234_5678_9ABC_DEF0_1357_2468_ACE0) begin errors++; $display("FAIL reset_m_dats got %h exp %h", m_dats, 128'h0F0F_1234_5678_9ABC_DEF0_1357_2468_ACE0); end
    next_cycle();
    rst = 1'b0;
    set_req(2, 1'b0);
    $display("test_reset: reset values checked");
  endtask

  task automatic test_single();
    logic          exp_cyc;
    logic [AW-1:0] exp_adr;
    logic [N-1:0]  exp_ack;
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      set_req(1, (c >= 3) && (c <= 6));
      s_ack = (c == 6);
      sample();
      exp_cyc = (c >= 4) && (c <= 6);
      exp_adr = exp_cyc ? adr_of(1) : '0;
      exp_ack = (c == 6) ? 4'b0010 : 4'b0000;
      checks++; if (s_cyc !== exp_cyc) begin errors++; $display("FAIL single_s_cyc c=%0d got %b exp %b", c, s_cyc, exp_cyc); end
      checks++; if (s_adr !== exp_adr) begin errors++; $display("FAIL single_s_adr c=%0d got %h exp %h", c, s_adr, exp_adr); end
      checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL single_m_ack c=%0d got %b exp %b", c, m_ack, exp_ack); end
    end
    $display("test_single: master 1 read of %h acknowledged", adr_of(1));
  endtask

  task automatic test_round_robin();
    int            k;
    logic          exp_cyc;
    logic [AW-1:0] exp_adr;
    logic [N-1:0]  exp_ack;
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      next_cycle();
      for (int i = 0; i < N; i++) set_req(i, 1'b1);
      s_ack = ((c % 4) == 3);
      sample();
      k       = (c / 4) % 4;
      exp_cyc = ((c % 4) != 0);
      exp_adr = exp_cyc ? adr_of(k) : '0;
      exp_ack = ((c % 4) == 3) ? 4'(1 << k) : 4'b0000;
      checks++; if (s_cyc !== exp_cyc) begin errors++; $display("FAIL rr_s_cyc c=%0d got %b exp %b", c, s_cyc, exp_cyc); end
      checks++; if (s_adr !== exp_adr) begin errors++; $display("FAIL rr_s_adr c=%0d got %h exp %h", c, s_adr, exp_adr); end
      checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL rr_m_ack c=%0d got %b exp %b", c, m_ack, exp_ack); end
      if ((c % 4) == 3) $display("test_round_robin: transfer to master %0d", k);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_write();
    logic busy;
    m_we[0] = 1'b1;
    m_sel[0 +: SELW] = 16'h00F0;
    m_datm[0 +: DW] = WDATA;
    for (int c = 0; c <= 5; c++) begin
      next_cycle();
      set_req(0, (c >= 1) && (c <= 3));
      s_ack = (c == 3);
      sample();
      busy = (c == 2) || (c == 3);
      checks++; if (s_we !== busy) begin errors++; $display("FAIL write_s_we c=%0d got %b exp %b", c, s_we, busy); end
      checks++; if (s_sel !== (busy ? 16'h00F0 : 16'h0000)) begin errors++; $display("FAIL write_s_sel c=%0d got %h exp %h", c, s_sel, busy ? 16'h00F0 : 16'h0000); end
      checks++; if (s_datm !== (busy ? WDATA : '0)) begin errors++; $display("FAIL write_s_datm c=%0d got %h exp %h", c, s_datm, busy ? WDATA : 128'h0); end
    end
    m_we[0] = 1'b0;
    $display("test_write: master 0 write of %h done", WDATA);
  endtask

  task automatic test_watchdog();
    logic         exp_cyc;
    logic         exp_err;
    logic [N-1:0] exp_rty;
    logic [N-1:0] exp_ack;
    for (int run = 0; run <= 1; run++) begin
      for (int c = 0; c <= 7; c++) begin
        next_cycle();
        set_req(2, (c >= 1) && (c <= 7));
        s_ack = (run == 1) && (c == 6);
        sample();
        exp_cyc = (c >= 2) && (c <= 5) || ((c == 6) && (run == 1));
        exp_err = (c == 6) && (run == 0);
        exp_rty = exp_err ? 4'b0100 : 4'b0000;
        exp_ack = ((c == 6) && (run == 1)) ? 4'b0100 : 4'b0000;
        checks++; if (s_cyc !== exp_cyc) begin errors++; $display("FAIL wdog_s_cyc run=%0d c=%0d got %b exp %b", run, c, s_cyc, exp_cyc); end
        checks++; if (timeout_err !== exp_err) begin errors++; $display("FAIL wdog_timeout_err run=%0d c=%0d got %b exp %b", run, c, timeout_err, exp_err); end
        checks++; if (m_rty !== exp_rty) begin errors++; $display("FAIL wdog_m_rty run=%0d c=%0d got %b exp %b", run, c, m_rty, exp_rty); end
        checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL wdog_m_ack run=%0d c=%0d got %b exp %b", run, c, m_ack, exp_ack); end
      end
      next_cycle();
      clear_inputs();
      $display("test_watchdog: run %0d master 2 transfer ended", run);
    end
  endtask

  task automatic test_rty();
    logic         exp_cyc;
    logic [N-1:0] exp_rty;
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      set_req(3, (c >= 1) && (c <= 3));
      s_rty = (c == 3);
      sample();
      exp_cyc = (c == 2) || (c == 3);
      exp_rty = (c == 3) ? 4'b1000 : 4'b0000;
      checks++; if (s_cyc !== exp_cyc) begin errors++; $display("FAIL rty_s_cyc c=%0d got %b exp %b", c, s_cyc, exp_cyc); end
      checks++; if (m_rty !== exp_rty) begin errors++; $display("FAIL rty_m_rty c=%0d got %b exp %b", c, m_rty, exp_rty); end
      checks++; if (m_ack !== 4'b0000) begin errors++; $display("FAIL rty_m_ack c=%0d got %b exp 0000", c, m_ack); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rty_timeout_err c=%0d got %b exp 0", c, timeout_err); end
    end
    $display("test_rty: master 3 transfer retried");
  endtask

  task automatic test_abort();
    logic          exp_cyc;
    logic [AW-1:0] exp_adr;
    logic [N-1:0]  exp_ack;
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      set_req(0, (c >= 1) && (c <= 3));
      set_req(1, (c >= 1) && (c <= 7));
      s_ack = (c == 7);
      sample();
      exp_cyc = (c == 2) || (c == 3) || (c == 6) || (c == 7);
      exp_adr = ((c == 2) || (c == 3)) ? adr_of(0) : (((c == 6) || (c == 7)) ? adr_of(1) : '0);
      exp_ack = (c == 7) ? 4'b0010 : 4'b0000;
      checks++; if (s_cyc !== exp_cyc) begin errors++; $display("FAIL abort_s_cyc c=%0d got %b exp %b", c, s_cyc, exp_cyc); end
      checks++; if (s_adr !== exp_adr) begin errors++; $display("FAIL abort_s_adr c=%0d got %h exp %h", c, s_adr, exp_adr); end
      checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL abort_m_ack c=%0d got %b exp %b", c, m_ack, exp_ack); end
    end
    $display("test_abort: master 0 aborted, master 1 acknowledged");
  endtask

  task automatic test_reset_mid();
    logic          exp_cyc;
    logic [AW-1:0] exp_adr;
    logic [N-1:0]  exp_ack;
    for (int c = 0; c <= 7; c++) begin
      next_cycle();
      rst = (c == 3);
      set_req(2, c >= 1);
      set_req(0, (c >= 4) && (c <= 5));
      s_ack = (c == 4) || (c == 5);
      sample();
      exp_cyc = (c == 2) || (c == 3) || (c == 5) || (c == 7);
      exp_adr = (c == 5) ? adr_of(0) : (exp_cyc ? adr_of(2) : '0);
      exp_ack = (c == 5) ? 4'b0001 : 4'b0000;
      checks++; if (s_cyc !== exp_cyc) begin errors++; $display("FAIL rstmid_s_cyc c=%0d got %b exp %b", c, s_cyc, exp_cyc); end
      checks++; if (s_adr !== exp_adr) begin errors++; $display("FAIL rstmid_s_adr c=%0d got %h exp %h", c, s_adr, exp_adr); end
      checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL rstmid_m_ack c=%0d got %b exp %b", c, m_ack, exp_ack); end
      checks++; if (m_rty !== 4'b0000) begin errors++; $display("FAIL rstmid_m_rty c=%0d got %b exp 0000", c, m_rty); end
    end
    next_cycle();
    clear_inputs();
    $display("test_reset_mid: master 0 granted first after reset");
  endtask

  initial begin
    rst    = 1'b1;
    s_dats = '0;
    m_sel  = '0;
    m_adr  = '0;
    m_datm = '0;
    clear_inputs();
    for (int i = 0; i < N; i++) begin
      m_adr[i * AW +: AW]    = adr_of(i);
      m_sel[i * SELW +: SELW] = SELW'(16'hF000 >> (4 * i));
      m_datm[i * DW +: DW]   = {4{32'(32'h1111_1111 * (i + 1))}};
    end
    test_reset();
    test_single();
    test_round_robin();
    test_write();
    test_watchdog();
    test_rty();
    test_abort();
    test_reset_mid();
    next_cycle();
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
